// File: rtl/gzip_pkg.sv
// Shared DEFLATE constants: fixed-Huffman length alphabet tables and helpers.
package gzip_pkg;

  // Number of length symbols actually used (257..285)
  localparam int LEN_SYMS = 29;

  // Fixed-Huffman length codes, symbols 257..279 are 7-bit, 280..287 are 8-bit
  localparam logic [7:0] LEN_CODE257 = 8'd1;
  localparam logic [7:0] LEN_CODE258 = 8'd2;
  localparam logic [7:0] LEN_CODE259 = 8'd3;
  localparam logic [7:0] LEN_CODE260 = 8'd4;
  localparam logic [7:0] LEN_CODE261 = 8'd5;
  localparam logic [7:0] LEN_CODE262 = 8'd6;
  localparam logic [7:0] LEN_CODE263 = 8'd7;
  localparam logic [7:0] LEN_CODE264 = 8'd8;
  localparam logic [7:0] LEN_CODE265 = 8'd9;
  localparam logic [7:0] LEN_CODE266 = 8'd10;
  localparam logic [7:0] LEN_CODE267 = 8'd11;
  localparam logic [7:0] LEN_CODE268 = 8'd12;
  localparam logic [7:0] LEN_CODE269 = 8'd13;
  localparam logic [7:0] LEN_CODE270 = 8'd14;
  localparam logic [7:0] LEN_CODE271 = 8'd15;
  localparam logic [7:0] LEN_CODE272 = 8'd16;
  localparam logic [7:0] LEN_CODE273 = 8'd17;
  localparam logic [7:0] LEN_CODE274 = 8'd18;
  localparam logic [7:0] LEN_CODE275 = 8'd19;
  localparam logic [7:0] LEN_CODE276 = 8'd20;
  localparam logic [7:0] LEN_CODE277 = 8'd21;
  localparam logic [7:0] LEN_CODE278 = 8'd22;
  localparam logic [7:0] LEN_CODE279 = 8'd23;
  localparam logic [7:0] LEN_CODE280 = 8'd192;
  localparam logic [7:0] LEN_CODE281 = 8'd193;
  localparam logic [7:0] LEN_CODE282 = 8'd194;
  localparam logic [7:0] LEN_CODE283 = 8'd195;
  localparam logic [7:0] LEN_CODE284 = 8'd196;
  localparam logic [7:0] LEN_CODE285 = 8'd197;
  localparam logic [7:0] LEN_CODE286 = 8'd198;
  localparam logic [7:0] LEN_CODE287 = 8'd199;

  // First symbol that uses an 8-bit code, as an index from symbol 257
  localparam logic [4:0] LONG_CODE_IDX = 5'd23;

  // Code table indexed by (symbol - 257)
  localparam logic [7:0] LEN_CODE [0:LEN_SYMS-1] = '{
    LEN_CODE257, LEN_CODE258, LEN_CODE259, LEN_CODE260, LEN_CODE261,
    LEN_CODE262, LEN_CODE263, LEN_CODE264, LEN_CODE265, LEN_CODE266,
    LEN_CODE267, LEN_CODE268, LEN_CODE269, LEN_CODE270, LEN_CODE271,
    LEN_CODE272, LEN_CODE273, LEN_CODE274, LEN_CODE275, LEN_CODE276,
    LEN_CODE277, LEN_CODE278, LEN_CODE279, LEN_CODE280, LEN_CODE281,
    LEN_CODE282, LEN_CODE283, LEN_CODE284, LEN_CODE285
  };

  // Smallest match length of each symbol, indexed by (symbol - 257)
  localparam logic [8:0] LEN_BASE [0:LEN_SYMS-1] = '{
    9'd3,   9'd4,   9'd5,   9'd6,   9'd7,   9'd8,   9'd9,   9'd10,
    9'd11,  9'd13,  9'd15,  9'd17,
    9'd19,  9'd23,  9'd27,  9'd31,
    9'd35,  9'd43,  9'd51,  9'd59,
    9'd67,  9'd83,  9'd99,  9'd115,
    9'd131, 9'd163, 9'd195, 9'd227,
    9'd258
  };

  // Extra-bit count of each symbol, indexed by (symbol - 257)
  localparam logic [2:0] LEN_EXTRA [0:LEN_SYMS-1] = '{
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd1, 3'd1, 3'd1,
    3'd2, 3'd2, 3'd2, 3'd2,
    3'd3, 3'd3, 3'd3, 3'd3,
    3'd4, 3'd4, 3'd4, 3'd4,
    3'd5, 3'd5, 3'd5, 3'd5,
    3'd0
  };

  // Legal match length window
  localparam logic [8:0] MIN_MATCH = 9'd3;
  localparam logic [8:0] MAX_MATCH = 9'd258;

  // Marker emitted for lengths above the legal window
  localparam logic [12:0] INVALID_DATA = 13'h0080;
  localparam logic [3:0]  INVALID_BITS = 4'd8;

  // One encoded length packet
  typedef struct packed {
    logic [12:0] data;
    logic [3:0]  nbits;
  } slength_pkt_t;

  localparam slength_pkt_t PKT_RESET = 17'h00000;

  // Reverse the low 'width' bits of a code (width is 7 or 8); bit 0 gets the code MSB
  function automatic logic [7:0] bit_reverse(input logic [7:0] code, input logic [3:0] width);
    logic [7:0] full_rev;
    logic [3:0] shift;
    full_rev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      full_rev[i] = code[7-i];
    end
    shift = 4'd8 - width;
    return full_rev >> shift;
  endfunction

endpackage

// File: rtl/slength_lut.sv
// Combinational match length -> fixed-Huffman length packet lookup.
module slength_lut
  import gzip_pkg::*;
(
  input  logic [8:0]   match_length_i,
  output slength_pkt_t pkt_o
);

  logic [4:0]  sym_idx_s;
  logic [8:0]  base_s;
  logic [8:0]  diff_s;
  logic [4:0]  extra_val_s;
  logic [2:0]  extra_cnt_s;
  logic [3:0]  code_len_s;
  logic [7:0]  code_rev_s;
  logic [12:0] packed_s;

  // Range decode: pick the highest symbol whose base does not exceed the length
  always_comb begin
    sym_idx_s = 5'd0;
    for (int i = 0; i < LEN_SYMS; i++) begin
      sym_idx_s = (match_length_i >= LEN_BASE[i]) ? 5'(i) : sym_idx_s;
    end
  end

  // Extra value, code length and bit-reversed code for the chosen symbol
  always_comb begin
    base_s      = LEN_BASE[sym_idx_s];
    extra_cnt_s = LEN_EXTRA[sym_idx_s];
    diff_s      = match_length_i - base_s;
    // Lengths below the legal window fall onto symbol 257 with no extra bits
    if (match_length_i >= base_s) begin
      extra_val_s = diff_s[4:0];
    end else begin
      extra_val_s = 5'd0;
    end
    if (sym_idx_s < LONG_CODE_IDX) begin
      code_len_s = 4'd7;
    end else begin
      code_len_s = 4'd8;
    end
    code_rev_s = bit_reverse(LEN_CODE[sym_idx_s], code_len_s);
    packed_s   = {5'b00000, code_rev_s} | ({8'h00, extra_val_s} << code_len_s);
  end

  // Final packet, overriding with the invalid marker above the legal window
  always_comb begin
    pkt_o = PKT_RESET;
    if (match_length_i > MAX_MATCH) begin
      pkt_o.data  = INVALID_DATA;
      pkt_o.nbits = INVALID_BITS;
    end else begin
      pkt_o.data  = packed_s;
      pkt_o.nbits = code_len_s + {1'b0, extra_cnt_s};
    end
  end

endmodule

// File: rtl/slength.sv
// Static-Huffman length encoder: registers one encoded length packet per cycle.
module slength
  import gzip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  match_length_in,
  output logic [12:0] slength_data_out,
  output logic [3:0]  slength_valid_bits
);

  slength_pkt_t lut_pkt_s;
  slength_pkt_t pkt_d;
  slength_pkt_t pkt_q;

  slength_lut u_lut (
    .match_length_i (match_length_in),
    .pkt_o          (lut_pkt_s)
  );

  // Next packet is simply the lookup result; the encoder runs every cycle
  always_comb begin
    pkt_d = lut_pkt_s;
  end

  // Output register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= PKT_RESET;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign slength_data_out   = pkt_q.data;
  assign slength_valid_bits = pkt_q.nbits;

endmodule

// File: tb/tb_slength.sv
// Scoreboard bench for slength against an arithmetic model of the length alphabet.
module tb_slength;

  logic        clk;
  logic        rst_n;
  logic [8:0]  match_length_in;
  logic [12:0] slength_data_out;
  logic [3:0]  slength_valid_bits;

  int total;
  int bad;

  typedef struct {
    int          len;
    logic [12:0] data;
    logic [3:0]  nbits;
  } exp_t;

  exp_t exp_q[$];

  slength dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .match_length_in    (match_length_in),
    .slength_data_out   (slength_data_out),
    .slength_valid_bits (slength_valid_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: symbol from log2 of (len-3), code from the fixed alphabet rules
  function automatic exp_t model(input int len_in);
    exp_t r;
    int len, d, lg, e, sym, extra, h, code, rev;
    r.len = len_in;
    if (len_in > 258) begin
      r.data  = 13'h0080;
      r.nbits = 4'd8;
      return r;
    end
    len = (len_in < 3) ? 3 : len_in;
    if (len == 258) begin
      sym = 285; e = 0; extra = 0;
    end else if (len <= 10) begin
      sym = 254 + len; e = 0; extra = 0;
    end else begin
      d  = len - 3;
      lg = 0;
      while ((d >> (lg + 1)) != 0) lg++;
      e     = lg - 2;
      sym   = 257 + 4 * e + (d >> e);
      extra = d & ((1 << e) - 1);
    end
    if (sym < 280) begin
      h = 7; code = sym - 256;
    end else begin
      h = 8; code = 192 + sym - 280;
    end
    rev = 0;
    for (int i = 0; i < h; i++) rev |= ((code >> (h - 1 - i)) & 1) << i;
    r.data  = 13'(rev | (extra << h));
    r.nbits = 4'(h + e);
    return r;
  endfunction

  task automatic check(input string name, input int len,
                       input logic [12:0] got_d, input logic [3:0] got_v,
                       input logic [12:0] exp_d, input logic [3:0] exp_v);
    total++;
    if (got_d !== exp_d || got_v !== exp_v) begin
      bad++;
      $display("FAIL %s len=%0d got data=%h bits=%0d expected data=%h bits=%0d",
               name, len, got_d, got_v, exp_d, exp_v);
    end
  endtask

  // Monitor: compare each registered output with the oldest pending expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("encode", e.len, slength_data_out, slength_valid_bits, e.data, e.nbits);
    end
  end

  task automatic drive(input int len);
    @(negedge clk);
    match_length_in = 9'(len);
    exp_q.push_back(model(len));
  endtask

  // Spot-check the model itself against hand-derived encodings
  task automatic model_check(input int len, input logic [12:0] d, input logic [3:0] v);
    exp_t m;
    m = model(len);
    check("table", len, m.data, m.nbits, d, v);
  endtask

  int directed [$] = '{0, 3, 10, 12, 22, 34, 42, 114, 115, 128, 131, 162, 257, 258, 259, 479,
                       1, 2, 11, 18, 19, 35, 66, 67, 130, 256, 511};

  initial begin
    int waited;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    match_length_in = 9'd100;

    // Reset held: outputs stay zero even though the input is changing
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check("reset", int'(match_length_in), slength_data_out, slength_valid_bits, 13'h0000, 4'd0);
      match_length_in = 9'($urandom_range(0, 511));
    end

    model_check(0,   13'h0040, 4'd7);
    model_check(10,  13'h0008, 4'd7);
    model_check(22,  13'h01D8, 4'd9);
    model_check(34,  13'h0184, 4'd9);
    model_check(42,  13'h03C4, 4'd10);
    model_check(114, 13'h07F4, 4'd11);
    model_check(128, 13'h0D03, 4'd12);
    model_check(162, 13'h1F83, 4'd13);
    model_check(257, 13'h1E23, 4'd13);
    model_check(258, 13'h00A3, 4'd8);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (directed[i]) drive(directed[i]);
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 8) == 0) drive(int'($urandom_range(0, 511)));
      else drive(int'($urandom_range(3, 258)));
    end

    // Mid-stream asynchronous reset must clear a non-zero output at once
    drive(162);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 162, slength_data_out, slength_valid_bits, 13'h0000, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) drive(int'($urandom_range(0, 300)));

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL timeout reached expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slength.md
Name: slength

Overview:
- Static-Huffman length encoder for the GZIP/DEFLATE compressor (RFC 1951, fixed-Huffman block).
- Converts an LZ77 match length (3..258) into one LSB-first bit packet: the bit-reversed fixed Huffman length code (symbols 257..285), followed by the extra bits.
- Output is registered and feeds the bit packer together with a count of valid bits.

Parameters:
- None. All widths are fixed by RFC 1951.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- match_length_in  in  9  match length; legal range 3..258.
- slength_data_out  out  13  packed code: Huffman code in the LSBs, bit-reversed; extra bits directly above it.
- slength_valid_bits  out  4  number of valid LSBs in slength_data_out (7..13).

Behaviour:
- Reset: slength_data_out=0 and slength_valid_bits=0, asserted asynchronously while rst_n=0.
- Latency: one cycle, no handshake.
  - On every rising clk edge, the outputs register the encoding of the current match_length_in.
  - The outputs hold until the next edge.
  - The encoder runs every cycle.
- Symbol, base and extra-bit count (E):
  - 3..10 -> symbols 257..264, E=0.
  - 11..18 -> 265..268, bases 11/13/15/17, E=1.
  - 19..34 -> 269..272, bases 19/23/27/31, E=2.
  - 35..66 -> 273..276, bases 35/43/51/59, E=3.
  - 67..130 -> 277..280, bases 67/83/99/115, E=4.
  - 131..257 -> 281..284, bases 131/163/195/227, E=5.
  - 258 -> 285, E=0.
- Extra-bit value = length - base.
  - Length 257 maps to symbol 284 with extra value 30; value 31 is never produced.
- Huffman code (H bits):
  - Symbols 257..279: H=7, code = symbol-256.
  - Symbols 280..285: H=8, code = 8'b11000000 + (symbol-280).
- Packing:
  - bits[H-1:0] = Huffman code reversed; the code MSB sits at bit 0.
  - bits[H+E-1:H] = extra value in natural order (its LSB at bit H).
  - All higher bits are 0.
  - slength_valid_bits = H+E.
- Out-of-range inputs:
  - 0..2: encode as symbol 257 with H=7 and E=0, giving data=13'h0040, valid=7.
  - 259..511: data=13'h0080, valid=8. This is the 8-bit pattern 8'b00000001 bit-reversed, an invalid-marker.
- Datapath: purely combinational range decode and lookup feeding one 17-bit register (13 data + 4 count). No FSM.

Decomposition:
- Shared package (gzip_pkg), holding:
  - the length-base table;
  - the extra-bit-count table;
  - fixed-Huffman length-code constants LEN_CODE257..LEN_CODE287 (7-bit 1..23, 8-bit 192..199);
  - a bit-reverse function.
- One natural sub-module, slength_lut: a combinational match length -> {reversed code, extra value, H+E} lookup. The top level only registers its output.

Test Plan:
- Reset and early lengths: hold rst_n=0 for 15 cycles -> outputs 0. Then apply:
  - 0 -> 13'h040, valid 7;
  - 3 -> 13'h040, valid 7;
  - 10 (symbol 264) -> 13'h008, valid 7.
- 1- and 2-extra-bit ranges:
  - 12 -> 13'h0C8, valid 8;
  - 22 -> 13'h1D8, valid 9;
  - 34 (symbol 272 = 7'b0010000) -> 13'h184, valid 9.
- 3- and 4-extra-bit ranges:
  - 42 (symbol 273) -> 13'h3C4, valid 10;
  - 114 (symbol 279) -> 13'h7F4, valid 11;
  - 115 (symbol 280) -> 13'h003, valid 12;
  - 128 -> 13'hD03, valid 12.
- 5-extra-bit range:
  - 131 -> 13'h083, valid 13;
  - 162 -> 13'h1F83, valid 13;
  - 257 -> 13'h1E23, valid 13.
- Max length and invalid inputs:
  - 258 -> 13'h0A3, valid 8;
  - 259 -> 13'h080, valid 8;
  - 479 -> 13'h080, valid 8.
- Back-to-back changes: new length every cycle -> each output matches the previous cycle's input. Assert rst_n low mid-stream -> outputs go to 0 immediately.
